uart_monitor_ctrl: RTL and testbench

- Command sequencer between the UART core and an 8-bit synchronous memory port on the iCE40 board.
- Parses a 3-byte header from the serial stream: address high, address low, command/count.
- Then performs one of three operations:
  - LOAD: serial bytes are written to memory.
  - DUMP: memory bytes are streamed out on TX.
  - EXEC: a start pulse is handed to an execution unit.
- LOAD and DUMP end with an 8-bit checksum byte. A receive timeout returns the block to idle.

---
 rtl/uart_monitor_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_monitor_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_monitor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_monitor_ctrl
// Description : UART-driven memory monitor. Parses a 3-byte header
//               (addr hi, addr lo, op/count) then performs LOAD (serial ->
//               memory), DUMP (memory -> serial) or EXEC (start pulse).
//               LOAD/DUMP finish with an 8-bit additive checksum on TX.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_monitor_ctrl #(
    parameter int ECHO           = 1,
    parameter int TIMEOUT_CYCLES = 12000000,
    parameter int TO_W           = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] exec_addr,
    output logic        exec_start,
    input  logic        exec_done,
    output logic        busy,
    output logic        timeout,
    output logic [3:0]  state_out
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR_LO   = 4'd1;
    localparam logic [3:0] S_CMD       = 4'd2;
    localparam logic [3:0] S_DISPATCH  = 4'd3;
    localparam logic [3:0] S_LOAD      = 4'd4;
    localparam logic [3:0] S_DUMP_RD   = 4'd5;
    localparam logic [3:0] S_DUMP_TX   = 4'd6;
    localparam logic [3:0] S_GAP       = 4'd7;
    localparam logic [3:0] S_SUM       = 4'd8;
    localparam logic [3:0] S_EXEC      = 4'd9;
    localparam logic [3:0] S_EXEC_WAIT = 4'd10;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]      state;
    logic [3:0]      state_next;
    logic [15:0]     addr;
    logic [1:0]      op;
    logic [5:0]      cnt;
    logic [7:0]      sum;
    logic [7:0]      tx_hold;
    logic [7:0]      tx_data;
    logic            tx_prev;
    logic [TO_W-1:0] to_cnt;
    logic            timed_state;
    logic            to_expire;
    logic            tx_ok;

    // Only the header and LOAD phases wait on the remote side, so only they time out.
    assign timed_state = (state == S_ADDR_LO) || (state == S_CMD) || (state == S_LOAD);
    // A byte arriving on the expiry cycle takes priority over the abort.
    assign to_expire   = timed_state && !received && (to_cnt == TO_LAST);
    // Never issue back-to-back requests; the UART needs a cycle to raise busy.
    assign tx_ok       = !is_transmitting && !tx_prev;

    assign mem_addr  = addr;
    assign busy      = (state != S_IDLE);
    assign state_out = state;
    // The byte being requested is visible in the request cycle and held afterwards.
    assign tx_byte   = transmit ? tx_data : tx_hold;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (received) state_next = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                if (received)       state_next = S_CMD;
                else if (to_expire) state_next = S_IDLE;
            end
            S_CMD: begin
                if (received)       state_next = S_DISPATCH;
                else if (to_expire) state_next = S_IDLE;
            end
            S_DISPATCH: begin
                case (op)
                    2'b00:   state_next = S_IDLE;
                    2'b01:   state_next = (cnt == 6'd0) ? S_SUM : S_LOAD;
                    2'b10:   state_next = (cnt == 6'd0) ? S_SUM : S_DUMP_RD;
                    default: state_next = S_EXEC;
                endcase
            end
            S_LOAD: begin
                if (received) begin
                    if (cnt == 6'd1) state_next = S_SUM;
                end else if (to_expire) begin
                    state_next = S_IDLE;
                end
            end
            S_DUMP_RD: begin
                if (!is_transmitting) state_next = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                state_next = (cnt != 6'd0) ? S_DUMP_RD : S_SUM;
            end
            S_SUM: begin
                if (tx_ok) state_next = S_IDLE;
            end
            S_EXEC: begin
                state_next = S_EXEC_WAIT;
            end
            S_EXEC_WAIT: begin
                if (exec_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle strobes and the TX data selection.
    always_comb begin
        transmit   = 1'b0;
        tx_data    = tx_hold;
        mem_we     = 1'b0;
        mem_wdata  = 8'h00;
        mem_re     = 1'b0;
        exec_start = 1'b0;
        timeout    = to_expire;
        case (state)
            S_IDLE, S_ADDR_LO, S_CMD: begin
                if ((ECHO != 0) && received && tx_ok) begin
                    transmit = 1'b1;
                    tx_data  = rx_byte;
                end
            end
            S_LOAD: begin
                if (received) begin
                    mem_we    = 1'b1;
                    mem_wdata = rx_byte;
                end
            end
            S_DUMP_RD: begin
                mem_re = !is_transmitting;
            end
            S_DUMP_TX: begin
                transmit = 1'b1;
                tx_data  = mem_rdata;
            end
            S_SUM: begin
                if (tx_ok) begin
                    transmit = 1'b1;
                    tx_data  = sum;
                end
            end
            S_EXEC: begin
                exec_start = 1'b1;
            end
            default: ;
        endcase
    end

    // Header capture, address/count/checksum bookkeeping and TX hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= 16'h0000;
            op        <= 2'b00;
            cnt       <= 6'd0;
            sum       <= 8'h00;
            tx_hold   <= 8'h00;
            tx_prev   <= 1'b0;
            exec_addr <= 16'h0000;
        end else begin
            tx_prev <= transmit;
            if (transmit) tx_hold <= tx_data;
            case (state)
                S_IDLE: begin
                    if (received) addr[15:8] <= rx_byte;
                end
                S_ADDR_LO: begin
                    if (received) addr[7:0] <= rx_byte;
                end
                S_CMD: begin
                    if (received) begin
                        op  <= rx_byte[7:6];
                        cnt <= rx_byte[5:0];
                        sum <= 8'h00;
                    end
                end
                S_LOAD: begin
                    if (received) begin
                        sum  <= sum + rx_byte;
                        addr <= addr + 16'd1;
                        cnt  <= cnt - 6'd1;
                    end
                end
                S_DUMP_TX: begin
                    sum  <= sum + mem_rdata;
                    addr <= addr + 16'd1;
                    cnt  <= cnt - 6'd1;
                end
                S_EXEC: begin
                    exec_addr <= addr;
                end
                default: ;
            endcase
        end
    end

    // Receive-inactivity counter; restarts on any byte or state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (received || (state_next != state) || !timed_state) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_monitor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_monitor_ctrl
// Description : Directed scoreboard bench for uart_monitor_ctrl with a simple
//               UART-busy model and a synchronous 64 KiB memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_monitor_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [15:0] exec_addr;
    logic        exec_start;
    logic        exec_done = 1'b0;
    logic        busy;
    logic        timeout;
    logic [3:0]  state_out;

    int checks = 0;
    int errors = 0;
    int to_count = 0;
    int re_count = 0;

    logic [7:0]  exp_tx[$];
    logic [23:0] exp_wr[$];
    logic [15:0] exp_exec[$];

    logic [7:0]  mem [0:65535];
    logic [3:0]  busy_cnt;

    uart_monitor_ctrl #(
        .ECHO(1),
        .TIMEOUT_CYCLES(100),
        .TO_W(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .received(received),
        .rx_byte(rx_byte),
        .is_transmitting(is_transmitting),
        .transmit(transmit),
        .tx_byte(tx_byte),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .exec_addr(exec_addr),
        .exec_start(exec_start),
        .exec_done(exec_done),
        .busy(busy),
        .timeout(timeout),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    // UART TX model: busy for 10 cycles after each request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                busy_cnt <= 4'd0;
        else if (transmit)         busy_cnt <= 4'd10;
        else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
    end
    assign is_transmitting = (busy_cnt != 4'd0);

    // Memory model: synchronous read, preload of the dump region during reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[16'h0100] <= 8'h10;
            mem[16'h0101] <= 8'hF5;
            mem[16'h0102] <= 8'h01;
            mem_rdata     <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (transmit) begin
                if (exp_tx.size() == 0) check("tx_unexpected", {24'h0, tx_byte}, 32'hFFFF_FFFF);
                else                    check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_tx.pop_front()});
            end
            if (mem_we) begin
                if (exp_wr.size() == 0) check("wr_unexpected", {8'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                else                    check("mem_write", {8'h0, mem_addr, mem_wdata}, {8'h0, exp_wr.pop_front()});
            end
            if (exec_start) begin
                if (exp_exec.size() == 0) check("exec_unexpected", {16'h0, mem_addr}, 32'hFFFF_FFFF);
                else                      check("exec_addr", {16'h0, mem_addr}, {16'h0, exp_exec.pop_front()});
            end
            if (mem_re) begin
                re_count++;
                check("mem_re_conflict", {31'h0, is_transmitting | mem_we}, 32'h0);
            end
            if (timeout) to_count++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (is_transmitting && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_wait_expired", 32'h1, 32'h0);
        @(negedge clk);
        rx_byte  = b;
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((state_out != 4'd0 || is_transmitting) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {28'h0, state_out}, 32'h0);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n = 0;
        while (state_out != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("state_reached", {28'h0, state_out}, {28'h0, s});
    endtask

    task automatic push_hdr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        exp_tx.push_back(c);
    endtask

    task automatic send_hdr(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    initial begin
        int n;
        int re_snap;
        repeat (3) @(negedge clk);
        check("rst_state", {28'h0, state_out}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_transmit", {31'h0, transmit}, 32'h0);
        check("rst_addr", {16'h0, mem_addr}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LOAD one byte
        push_hdr(8'h12, 8'h34, 8'h41);
        exp_wr.push_back({16'h1234, 8'hAA});
        exp_tx.push_back(8'hAA);
        send_hdr(8'h12, 8'h34, 8'h41);
        send_byte(8'hAA);
        wait_idle(100);

        // LOAD with address wrap
        push_hdr(8'hFF, 8'hFF, 8'h42);
        exp_wr.push_back({16'hFFFF, 8'h01});
        exp_wr.push_back({16'h0000, 8'h02});
        exp_tx.push_back(8'h03);
        send_hdr(8'hFF, 8'hFF, 8'h42);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_idle(100);

        // DUMP three bytes
        push_hdr(8'h01, 8'h00, 8'h83);
        exp_tx.push_back(8'h10);
        exp_tx.push_back(8'hF5);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h06);
        send_hdr(8'h01, 8'h00, 8'h83);
        wait_idle(300);
        check("dump_tx_drained", exp_tx.size(), 32'h0);

        // EXEC, stray byte ignored
        push_hdr(8'h20, 8'h00, 8'hC0);
        exp_exec.push_back(16'h2000);
        send_hdr(8'h20, 8'h00, 8'hC0);
        send_byte(8'h55);
        check("exec_wait_state", {28'h0, state_out}, 32'd10);
        check("exec_wait_busy", {31'h0, busy}, 32'h1);
        check("exec_addr_out", {16'h0, exec_addr}, 32'h2000);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        check("exec_done_state", {28'h0, state_out}, 32'h0);
        check("exec_done_busy", {31'h0, busy}, 32'h0);

        // LOAD abandoned by timeout
        push_hdr(8'h00, 8'h10, 8'h45);
        exp_wr.push_back({16'h0010, 8'h7E});
        send_hdr(8'h00, 8'h10, 8'h45);
        send_byte(8'h7E);
        n = 0;
        while (to_count == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_count", to_count, 32'h1);
        check("timeout_state", {28'h0, state_out}, 32'h0);
        repeat (20) @(negedge clk);

        // DUMP of zero length: checksum only, no reads
        re_snap = re_count;
        push_hdr(8'h00, 8'h00, 8'h80);
        exp_tx.push_back(8'h00);
        send_hdr(8'h00, 8'h00, 8'h80);
        wait_idle(100);
        check("zero_dump_no_re", re_count - re_snap, 32'h0);

        // Reset in the middle of a DUMP
        push_hdr(8'h01, 8'h00, 8'h82);
        exp_tx.push_back(8'h10);
        send_hdr(8'h01, 8'h00, 8'h82);
        wait_state(4'd7, 100);
        @(negedge clk);
        check("mid_dump_state", {28'h0, state_out}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_transmit", {31'h0, transmit}, 32'h0);
        check("rst_mid_mem_re", {31'h0, mem_re}, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_state", {28'h0, state_out}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        check("tx_queue_empty", exp_tx.size(), 32'h0);
        check("wr_queue_empty", exp_wr.size(), 32'h0);
        check("exec_queue_empty", exp_exec.size(), 32'h0);
        check("timeout_total", to_count, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
